// File: rtl/vrf_pkg.sv
// vrf_pkg: shared defaults, state enum and row/count types for the VRF read sequencer
package vrf_pkg;
   localparam int VRF_ROW       = 16;
   localparam int VRF_WIDTH     = 256;
   localparam int VRF_MAX_GRP   = 8;
   localparam int VRF_ROW_WIDTH = $clog2(VRF_ROW);
   localparam int VRF_CNT_W     = $clog2(VRF_MAX_GRP) + 1;
   typedef enum logic {IDLE, BUSY} rseq_state_e;
   typedef logic [VRF_ROW_WIDTH-1:0] row_addr_t;
   typedef logic [VRF_CNT_W-1:0]     grp_cnt_t;
endpackage

// File: rtl/vrf_rseq_out_stage.sv
// vrf_rseq_out_stage: registered output beat with valid/ready hold; write-forwarding under VRF_RSEQ_BYPASS_EN
module vrf_rseq_out_stage #(
   parameter int ROW_WIDTH = 4,
   parameter int WIDTH     = 256,
   parameter int CNT_W     = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 load,
   input  logic                 out_ready,
   input  logic [ROW_WIDTH-1:0] raddr1,
   input  logic [ROW_WIDTH-1:0] raddr2,
   input  logic [WIDTH-1:0]     rdata1,
   input  logic [WIDTH-1:0]     rdata2,
   input  logic                 wen,
   input  logic [ROW_WIDTH-1:0] waddr,
   input  logic [WIDTH-1:0]     wdata,
   input  logic [CNT_W-1:0]     idx,
   input  logic                 last,
   output logic                 out_valid,
   output logic [WIDTH-1:0]     out_data1,
   output logic [WIDTH-1:0]     out_data2,
   output logic [CNT_W-1:0]     out_idx,
   output logic                 out_last
);
   logic             valid_q, valid_d, last_q, last_d;
   logic [WIDTH-1:0] data1_q, data1_d, data2_q, data2_d, cap1, cap2;
   logic [CNT_W-1:0] idx_q, idx_d;
`ifdef VRF_RSEQ_BYPASS_EN
   assign cap1 = (wen && waddr == raddr1) ? wdata : rdata1;
   assign cap2 = (wen && waddr == raddr2) ? wdata : rdata2;
`else
   logic unused_snoop;
   assign unused_snoop = ^{wen, waddr, wdata, raddr1, raddr2};
   assign cap1 = rdata1;
   assign cap2 = rdata2;
`endif
   // capture a new beat on load, otherwise hold until the consumer takes it
   always_comb begin
      valid_d = load ? 1'b1 : (out_ready ? 1'b0 : valid_q);
      data1_d = load ? cap1 : data1_q;
      data2_d = load ? cap2 : data2_q;
      idx_d   = load ? idx  : idx_q;
      last_d  = load ? last : last_q;
   end
   // output registers, cleared by async reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data1_q <= '0;
         data2_q <= '0;
         idx_q   <= '0;
         last_q  <= 1'b0;
      end else begin
         valid_q <= valid_d;
         data1_q <= data1_d;
         data2_q <= data2_d;
         idx_q   <= idx_d;
         last_q  <= last_d;
      end
   end
   assign out_valid = valid_q;
   assign out_data1 = data1_q;
   assign out_data2 = data2_q;
   assign out_idx   = idx_q;
   assign out_last  = last_q;
endmodule

// File: rtl/vrf_read_sequencer.sv
// vrf_read_sequencer: walks a register group across both bank read ports and streams one beat per row
module vrf_read_sequencer
   import vrf_pkg::*;
#(
   parameter int ROW       = VRF_ROW,
   parameter int ROW_WIDTH = $clog2(ROW),
   parameter int WIDTH     = VRF_WIDTH,
   parameter int MAX_GRP   = VRF_MAX_GRP,
   parameter int CNT_W     = $clog2(MAX_GRP) + 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [ROW_WIDTH-1:0] req_vs1,
   input  logic [ROW_WIDTH-1:0] req_vs2,
   input  logic [CNT_W-1:0]     req_cnt,
   output logic [ROW_WIDTH-1:0] raddr1,
   output logic [ROW_WIDTH-1:0] raddr2,
   input  logic [WIDTH-1:0]     rdata1,
   input  logic [WIDTH-1:0]     rdata2,
   input  logic                 wen,
   input  logic [ROW_WIDTH-1:0] waddr,
   input  logic [WIDTH-1:0]     wdata,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     out_data1,
   output logic [WIDTH-1:0]     out_data2,
   output logic [CNT_W-1:0]     out_idx,
   output logic                 out_last
);
   rseq_state_e          state_q, state_d;
   logic [ROW_WIDTH-1:0] raddr1_q, raddr1_d, raddr2_q, raddr2_d;
   logic [CNT_W-1:0]     idx_q, idx_d, last_idx_q, last_idx_d, cnt_eff;
   logic                 load, at_last;
   assign cnt_eff   = (req_cnt == '0) ? CNT_W'(1) : (req_cnt > CNT_W'(MAX_GRP)) ? CNT_W'(MAX_GRP) : req_cnt;
   assign req_ready = (state_q == IDLE);
   assign load      = (state_q == BUSY) && (!out_valid || out_ready);
   assign at_last   = (idx_q == last_idx_q);
   // address registers track vs+idx; they stop on the last row so IDLE holds the final address
   always_comb begin
      state_d    = state_q;
      raddr1_d   = raddr1_q;
      raddr2_d   = raddr2_q;
      idx_d      = idx_q;
      last_idx_d = last_idx_q;
      if (state_q == IDLE && req_valid) begin
         state_d    = BUSY;
         raddr1_d   = req_vs1;
         raddr2_d   = req_vs2;
         idx_d      = '0;
         last_idx_d = cnt_eff - CNT_W'(1);
      end else if (load) begin
         idx_d    = idx_q + CNT_W'(1);
         state_d  = at_last ? IDLE : BUSY;
         raddr1_d = at_last ? raddr1_q : raddr1_q + ROW_WIDTH'(1);
         raddr2_d = at_last ? raddr2_q : raddr2_q + ROW_WIDTH'(1);
      end
   end
   // sequencer state, cleared by async reset which also drops any group in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         raddr1_q   <= '0;
         raddr2_q   <= '0;
         idx_q      <= '0;
         last_idx_q <= '0;
      end else begin
         state_q    <= state_d;
         raddr1_q   <= raddr1_d;
         raddr2_q   <= raddr2_d;
         idx_q      <= idx_d;
         last_idx_q <= last_idx_d;
      end
   end
   assign raddr1 = raddr1_q;
   assign raddr2 = raddr2_q;
   vrf_rseq_out_stage #(
      .ROW_WIDTH(ROW_WIDTH),
      .WIDTH    (WIDTH),
      .CNT_W    (CNT_W)
   ) u_out (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load),
      .out_ready(out_ready),
      .raddr1   (raddr1_q),
      .raddr2   (raddr2_q),
      .rdata1   (rdata1),
      .rdata2   (rdata2),
      .wen      (wen),
      .waddr    (waddr),
      .wdata    (wdata),
      .idx      (idx_q),
      .last     (at_last),
      .out_valid(out_valid),
      .out_data1(out_data1),
      .out_data2(out_data2),
      .out_idx  (out_idx),
      .out_last (out_last)
   );
endmodule
